// File: rtl/dds_multiwave_if.sv
// Control, ROM and sample-output bundle of the multi-waveform DDS.
// master = control/key side (also hosts the sine ROM), slave = the DDS core.
interface dds_multiwave_if #(
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int AMP_W  = 8
);
    logic              en;
    logic              cfg_load;
    logic [ACC_W-1:0]  cfg_fword;
    logic [ADDR_W-1:0] cfg_pword;
    logic [1:0]        cfg_wave;
    logic [AMP_W:0]    cfg_amp;
    logic              phase_clr;
    logic              cfg_pending;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_q;
    logic              dds_valid;
    logic [DATA_W-1:0] dds_data;

    modport master (
        output en, cfg_load, cfg_fword, cfg_pword, cfg_wave, cfg_amp, phase_clr, rom_q,
        input  cfg_pending, rom_addr, dds_valid, dds_data
    );

    modport slave (
        input  en, cfg_load, cfg_fword, cfg_pword, cfg_wave, cfg_amp, phase_clr, rom_q,
        output cfg_pending, rom_addr, dds_valid, dds_data
    );
endinterface

// File: rtl/dds_multiwave.sv
// Phase-accumulator DDS: sine (external ROM), square, triangle, saw with amplitude scaling.
// Latency: accumulator value -> dds_data 3 clk; dds_valid is en delayed 3 clk.
// No backpressure: free-running one sample per clk while en is high.
module dds_multiwave #(
    parameter int ACC_W       = 32,
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 8,
    parameter int AMP_W       = 8,
    parameter int SYNC_UPDATE = 1
) (
    input logic            clk,
    input logic            rst_n,
    dds_multiwave_if.slave dds
);
    localparam int PW = DATA_W + AMP_W + 3;
    localparam logic [AMP_W:0]        AMP_ONE  = {1'b1, {AMP_W{1'b0}}};
    localparam logic [DATA_W-1:0]     MID      = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [PW-1:0]  LVL_MAX  = (PW'(1) <<< DATA_W) - PW'(1);
    localparam logic [1:0]            WAVE_SINE   = 2'd0;
    localparam logic [1:0]            WAVE_SQUARE = 2'd1;
    localparam logic [1:0]            WAVE_TRI    = 2'd2;
    localparam logic                  SYNC     = (SYNC_UPDATE != 0);

    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  r_sh_fword, r_act_fword;
    logic [ADDR_W-1:0] r_sh_pword, r_act_pword;
    logic [1:0]        r_sh_wave,  r_act_wave;
    logic [AMP_W:0]    r_sh_amp,   r_act_amp;
    logic              r_pending;

    logic [ADDR_W-1:0] r_phase;
    logic [1:0]        r_wave1, r_wave2;
    logic [AMP_W:0]    r_amp1,  r_amp2;
    logic [DATA_W-1:0] r_samp2;
    logic              r_v1, r_v2, r_v3;
    logic [DATA_W-1:0] r_data;

    logic [ACC_W:0]    w_acc_sum;
    logic              w_run, w_wrap, w_apply;
    logic [AMP_W:0]    w_amp_sat;
    logic [ADDR_W-1:0] w_phase;
    logic [DATA_W-1:0] w_samp;
    logic [DATA_W-1:0] w_sample;
    logic signed [DATA_W:0] w_s;
    logic signed [PW-1:0]   w_prod, w_scaled, w_lvl;
    logic [DATA_W-1:0] w_clip;

    assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_act_fword};
    assign w_run     = dds.en & ~dds.phase_clr;
    assign w_wrap    = w_run & w_acc_sum[ACC_W];
    assign w_amp_sat = (dds.cfg_amp > AMP_ONE) ? AMP_ONE : dds.cfg_amp;

    // A load landing on an apply event wins: the stale shadow is dropped, the new one waits.
    assign w_apply = r_pending & ~dds.cfg_load &
                     (~SYNC | w_wrap | ~dds.en | dds.phase_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (!w_run) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_fword  <= '0;
            r_sh_pword  <= '0;
            r_sh_wave   <= '0;
            r_sh_amp    <= '0;
            r_act_fword <= '0;
            r_act_pword <= '0;
            r_act_wave  <= '0;
            r_act_amp   <= '0;
            r_pending   <= 1'b0;
        end else begin
            if (w_apply) begin
                r_act_fword <= r_sh_fword;
                r_act_pword <= r_sh_pword;
                r_act_wave  <= r_sh_wave;
                r_act_amp   <= r_sh_amp;
            end
            if (dds.cfg_load) begin
                r_sh_fword <= dds.cfg_fword;
                r_sh_pword <= dds.cfg_pword;
                r_sh_wave  <= dds.cfg_wave;
                r_sh_amp   <= w_amp_sat;
                r_pending  <= 1'b1;
            end else if (w_apply) begin
                r_pending  <= 1'b0;
            end
        end
    end

    assign w_phase = r_acc[ACC_W-1 -: ADDR_W] + r_act_pword;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= '0;
            r_wave1 <= '0;
            r_amp1  <= '0;
            r_v1    <= 1'b0;
        end else begin
            r_phase <= w_phase;
            r_wave1 <= r_act_wave;
            r_amp1  <= r_act_amp;
            r_v1    <= dds.en;
        end
    end

    always_comb begin
        w_samp = '0;
        case (r_wave1)
            WAVE_SQUARE: w_samp = r_phase[ADDR_W-1] ? '0 : '1;
            WAVE_TRI:    w_samp = r_phase[ADDR_W-1] ? ~r_phase[ADDR_W-2 -: DATA_W]
                                                    :  r_phase[ADDR_W-2 -: DATA_W];
            WAVE_SINE:   w_samp = '0;
            default:     w_samp = r_phase[ADDR_W-1 -: DATA_W];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_samp2 <= '0;
            r_wave2 <= '0;
            r_amp2  <= '0;
            r_v2    <= 1'b0;
        end else begin
            r_samp2 <= w_samp;
            r_wave2 <= r_wave1;
            r_amp2  <= r_amp1;
            r_v2    <= r_v1;
        end
    end

    // The ROM answers one clk after rom_addr, i.e. in step with the stage-2 sample.
    assign w_sample = (r_wave2 == WAVE_SINE) ? dds.rom_q : r_samp2;
    assign w_s      = $signed({1'b0, w_sample} - {1'b0, MID});
    assign w_prod   = PW'(w_s) * PW'($signed({1'b0, r_amp2}));
    assign w_scaled = w_prod >>> AMP_W;
    assign w_lvl    = w_scaled + $signed(PW'(MID));

    always_comb begin
        w_clip = w_lvl[DATA_W-1:0];
        if (w_lvl[PW-1]) begin
            w_clip = '0;
        end else if (w_lvl > LVL_MAX) begin
            w_clip = '1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_v3   <= 1'b0;
        end else begin
            r_data <= r_v2 ? w_clip : '0;
            r_v3   <= r_v2;
        end
    end

    assign dds.cfg_pending = r_pending;
    assign dds.rom_addr    = r_phase;
    assign dds.dds_valid   = r_v3;
    assign dds.dds_data    = r_data;
endmodule

// File: tb/tb_dds_multiwave.sv
// Runs a SYNC_UPDATE=0 and a SYNC_UPDATE=1 DDS side by side against a cycle-level
// arithmetic model of the phase/config/sample rules.
module tb_dds_multiwave;
    localparam int ACC_W  = 32;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int AMP_W  = 8;
    localparam int UNIT   = 1 << 22;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        t_en    = 1'b0;
    logic        t_load  = 1'b0;
    logic        t_clr   = 1'b0;
    logic [31:0] t_fword = '0;
    logic [9:0]  t_pword = '0;
    logic [1:0]  t_wave  = '0;
    logic [8:0]  t_amp   = '0;

    dds_multiwave_if #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AMP_W(AMP_W)) if0 ();
    dds_multiwave_if #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AMP_W(AMP_W)) if1 ();

    assign if0.en = t_en;       assign if1.en = t_en;
    assign if0.cfg_load = t_load;   assign if1.cfg_load = t_load;
    assign if0.phase_clr = t_clr;   assign if1.phase_clr = t_clr;
    assign if0.cfg_fword = t_fword; assign if1.cfg_fword = t_fword;
    assign if0.cfg_pword = t_pword; assign if1.cfg_pword = t_pword;
    assign if0.cfg_wave = t_wave;   assign if1.cfg_wave = t_wave;
    assign if0.cfg_amp = t_amp;     assign if1.cfg_amp = t_amp;

    // Synchronous sine ROM stand-in: data = address LSBs.
    always @(posedge clk) begin
        if0.rom_q <= if0.rom_addr[7:0];
        if1.rom_q <= if1.rom_addr[7:0];
    end

    dds_multiwave #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AMP_W(AMP_W),
                    .SYNC_UPDATE(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .dds(if0.slave));
    dds_multiwave #(.ACC_W(ACC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .AMP_W(AMP_W),
                    .SYNC_UPDATE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .dds(if1.slave));

    logic [9:0] o_addr [2];
    logic [7:0] o_dat  [2];
    logic       o_vld  [2];
    logic       o_pend [2];
    assign o_addr[0] = if0.rom_addr;    assign o_addr[1] = if1.rom_addr;
    assign o_dat[0]  = if0.dds_data;    assign o_dat[1]  = if1.dds_data;
    assign o_vld[0]  = if0.dds_valid;   assign o_vld[1]  = if1.dds_valid;
    assign o_pend[0] = if0.cfg_pending; assign o_pend[1] = if1.cfg_pending;

    // Reference model state, one set per instance (0: immediate, 1: update at wrap).
    logic [31:0] m_acc [2];
    logic [31:0] m_af [2];
    logic [31:0] m_sf [2];
    int m_ap [2], m_sp [2], m_aw [2], m_sw [2], m_aa [2], m_sa [2];
    bit m_pend [2];
    bit m_v [2][3];
    int m_d [2][3];
    int m_addr [2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d want=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int ref_level(input int ph, input int w, input int amp);
        int smp, p, q;
        case (w)
            0:       smp = ph % 256;
            1:       smp = (ph >= 512) ? 0 : 255;
            2:       smp = (ph < 512) ? ph / 2 : (1023 - ph) / 2;
            default: smp = ph / 4;
        endcase
        p = (smp - 128) * amp;
        q = 128 + (p >>> 8);
        if (q < 0)   q = 0;
        if (q > 255) q = 255;
        return q;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_acc[m] = '0; m_af[m] = '0; m_sf[m] = '0;
            m_ap[m] = 0; m_sp[m] = 0; m_aw[m] = 0; m_sw[m] = 0; m_aa[m] = 0; m_sa[m] = 0;
            m_pend[m] = 1'b0; m_addr[m] = 0;
            for (int k = 0; k < 3; k++) begin
                m_v[m][k] = 1'b0;
                m_d[m][k] = 0;
            end
        end
    endtask

    task automatic model_step(input int m);
        int     ph;
        longint nxt;
        bit     carry, apply;
        ph = (int'(m_acc[m] / UNIT) + m_ap[m]) % 1024;
        m_v[m][2] = m_v[m][1]; m_v[m][1] = m_v[m][0]; m_v[m][0] = t_en;
        m_d[m][2] = m_d[m][1]; m_d[m][1] = m_d[m][0];
        m_d[m][0] = t_en ? ref_level(ph, m_aw[m], m_aa[m]) : 0;
        m_addr[m] = ph;
        nxt   = longint'(m_acc[m]) + longint'(m_af[m]);
        carry = t_en && !t_clr && (nxt >= 64'h1_0000_0000);
        apply = m_pend[m] && !t_load && (m == 0 || carry || !t_en || t_clr);
        m_acc[m] = (t_en && !t_clr) ? 32'(nxt) : 32'd0;
        if (apply) begin
            m_af[m] = m_sf[m]; m_ap[m] = m_sp[m]; m_aw[m] = m_sw[m]; m_aa[m] = m_sa[m];
        end
        if (t_load) begin
            m_sf[m] = t_fword; m_sp[m] = int'(t_pword); m_sw[m] = int'(t_wave);
            m_sa[m] = (t_amp > 9'd256) ? 256 : int'(t_amp);
            m_pend[m] = 1'b1;
        end else if (apply) begin
            m_pend[m] = 1'b0;
        end
    endtask

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("rom_addr%0d", m), longint'(o_addr[m]), longint'(m_addr[m]));
            check($sformatf("valid%0d", m),    longint'(o_vld[m]),  longint'(m_v[m][2]));
            check($sformatf("data%0d", m),     longint'(o_dat[m]),  longint'(m_d[m][2]));
            check($sformatf("pending%0d", m),  longint'(o_pend[m]), longint'(m_pend[m]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic load_cfg(input logic [31:0] f, input int p, input int w, input int a);
        t_en = 1'b0; t_fword = f; t_pword = 10'(p); t_wave = 2'(w); t_amp = 9'(a);
        t_load = 1'b1;
        tick();
        t_load = 1'b0;
        tick();
    endtask

    task automatic amp_case(input int a, input int exp);
        load_cfg(32'd0, 511, 2, a);
        t_en = 1'b1;
        repeat (4) tick();
        check($sformatf("tri_amp%0d_i0", a), longint'(o_dat[0]), longint'(exp));
        check($sformatf("tri_amp%0d_i1", a), longint'(o_dat[1]), longint'(exp));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int prev;
        model_reset();
        #1;
        for (int m = 0; m < 2; m++) begin
            check($sformatf("rst_vld%0d", m),  longint'(o_vld[m]),  0);
            check($sformatf("rst_dat%0d", m),  longint'(o_dat[m]),  0);
            check($sformatf("rst_pend%0d", m), longint'(o_pend[m]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();

        // Saw linearity from a deterministic start.
        load_cfg(UNIT, 0, 3, 256);
        t_en = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!o_vld[0] && n < 10);
        check("saw_valid_lat", n, 3);
        n = 0;
        while (o_dat[0] != 8'd255 && n < 2000) begin tick(); n++; end
        check("saw_peak_phase", n, 1020);
        repeat (10) tick();

        // Sine path through the ROM.
        load_cfg(32'd3 * UNIT + 32'd12345, 7, 0, 256);
        t_en = 1'b1;
        repeat (600) tick();

        // Phase offset with square wave.
        load_cfg(UNIT, 512, 1, 256);
        t_en = 1'b1;
        repeat (3) tick();
        check("sq_first_vld", longint'(o_vld[0]), 1);
        check("sq_first", longint'(o_dat[0]), 0);
        repeat (511) tick();
        check("sq_hold", longint'(o_dat[0]), 0);
        tick();
        check("sq_toggle", longint'(o_dat[0]), 255);

        // Amplitude scaling at the triangle peak.
        amp_case(128, 191);
        amp_case(0, 128);
        amp_case(511, 255);
        amp_case(64, 159);

        // Update at wrap vs immediate.
        load_cfg(UNIT, 0, 3, 256);
        t_en = 1'b1;
        repeat (100) tick();
        t_fword = 2 * UNIT; t_load = 1'b1;
        tick();
        t_load = 1'b0;
        check("sync_pend_set", longint'(o_pend[1]), 1);
        tick();
        check("imm_applied", longint'(o_pend[0]), 0);
        check("sync_pend_hold", longint'(o_pend[1]), 1);
        n = 0;
        while (o_pend[1] && n < 2000) begin tick(); n++; end
        check("sync_wrap_wait", n, 922);

        // Two loads before the wrap: only the later one counts.
        repeat (50) tick();
        t_fword = 3 * UNIT; t_load = 1'b1;
        tick();
        t_fword = 5 * UNIT;
        tick();
        t_load = 1'b0;
        repeat (600) tick();
        prev = int'(o_addr[1]);
        tick();
        check("two_load_step", longint'((int'(o_addr[1]) - prev + 1024) % 1024), 5);

        // phase_clr applies a pending config and zeroes the accumulator.
        t_clr = 1'b1; tick(); t_clr = 1'b0;
        t_fword = UNIT; t_load = 1'b1;
        tick();
        t_load = 1'b0;
        tick();
        check("clr_pre_pend", longint'(o_pend[1]), 1);
        t_clr = 1'b1;
        tick();
        t_clr = 1'b0;
        check("clr_pend", longint'(o_pend[1]), 0);
        tick();
        check("clr_addr", longint'(o_addr[1]), 0);

        // Randomised run.
        for (int i = 0; i < 3000; i++) begin
            t_en    = ($urandom_range(0, 15) != 0);
            t_load  = ($urandom_range(0, 19) == 0);
            t_clr   = ($urandom_range(0, 49) == 0);
            t_fword = $urandom() >> $urandom_range(0, 12);
            t_pword = 10'($urandom());
            t_wave  = 2'($urandom());
            t_amp   = 9'($urandom());
            tick();
        end
        t_load = 1'b0; t_clr = 1'b0;

        // Asynchronous reset in the middle of a run.
        load_cfg(7 * UNIT, 3, 3, 256);
        t_en = 1'b1;
        repeat (20) tick();
        #2 rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            check($sformatf("arst_vld%0d", m),  longint'(o_vld[m]),  0);
            check($sformatf("arst_dat%0d", m),  longint'(o_dat[m]),  0);
            check($sformatf("arst_addr%0d", m), longint'(o_addr[m]), 0);
        end
        model_reset();
        t_en = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("post_rst_pend", longint'(o_pend[1]), 0);
        check("post_rst_vld", longint'(o_vld[0]), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
